// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, next-PC selection (jump / taken branch / increment)
// and an IDLE/STEP/RUN/HALT sequencer with a synchronized single-step input.
module fetch_unit #(
  parameter int              N        = 8,
  parameter logic [N-1:0]    RESET_PC = '0,
  parameter int              RUN_DIV  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         run,
  input  logic [31:0]  instr,
  input  logic         branch,
  input  logic         zero,
  input  logic         jump,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus1,
  output logic         advance,
  output logic         halted,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_STEP = 2'b01,
    S_RUN  = 2'b10,
    S_HALT = 2'b11
  } state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [7:0]  CNT_TERM  = 8'(RUN_DIV - 1);

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         s1_q, s2_q, s3_q;
  logic         step_edge;
  logic         halt_word;
  logic         cnt_term;
  logic [N-1:0] next_pc;

  assign step_edge = s2_q & ~s3_q;
  assign halt_word = (instr == HALT_WORD);
  assign cnt_term  = (cnt_q == CNT_TERM);

  assign pc_plus1 = pc_q + N'(1);
  assign next_pc  = jump            ? instr[N-1:0] :
                    (branch & zero) ? pc_plus1 + instr[N-1:0] :
                                      pc_plus1;
  assign pc_d     = advance ? next_pc : pc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset forces the whole sequencer to a known state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      s1_q    <= step;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (run)            state_d = S_RUN;
        else if (step_edge) state_d = S_STEP;
      end
      S_STEP: state_d = halt_word ? S_HALT : S_IDLE;
      S_RUN: begin
        if (!run)                       state_d = S_IDLE;
        else if (cnt_term && halt_word) state_d = S_HALT;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Divider count is held at zero outside RUN, so entering RUN starts from zero.
  always_comb begin
    advance = 1'b0;
    cnt_d   = '0;
    unique case (state_q)
      S_STEP: advance = ~halt_word;
      S_RUN: begin
        if (run) begin
          if (cnt_term) advance = ~halt_word;
          else          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign halted = (state_q == S_HALT);
  assign state  = state_q;
  assign pc     = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: stepping, next-PC selection,
// run-mode pacing, halt behaviour and reset abort.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        step, run, branch, zero, jump;
  logic [31:0] instr;
  logic [7:0]  pc, pc_plus1;
  logic        advance, halted;
  logic [1:0]  state;

  int checks  = 0;
  int errors  = 0;
  int adv_cnt = 0;

  fetch_unit #(.N(8), .RESET_PC(8'h00), .RUN_DIV(4)) dut (
    .clk(clk), .rst(rst), .step(step), .run(run), .instr(instr),
    .branch(branch), .zero(zero), .jump(jump), .pc(pc), .pc_plus1(pc_plus1),
    .advance(advance), .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count an advance seen in the closing cycle, then move to just after the next edge.
  task automatic cycle();
    #2;
    if (advance === 1'b1) adv_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input string tag, input logic [7:0] exp_pc);
    int a0;
    a0 = adv_cnt;
    step = 1'b1;
    repeat (2) cycle();
    step = 1'b0;
    repeat (6) cycle();
    check({tag, "_adv"}, adv_cnt - a0, 1);
    check({tag, "_pc"}, pc, exp_pc);
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    cycle();
  endtask

  initial begin
    int a0;
    rst = 1'b0; step = 1'b0; run = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0;
    instr = 32'h2001_0005;
    #12;
    check("rst_pc", pc, 8'h00);
    check("rst_state", state, 2'b00);
    check("rst_adv", advance, 1'b0);
    check("rst_halted", halted, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycle();

    // Single step: advance appears only after the third sampling edge.
    step = 1'b1;
    repeat (2) cycle();
    check("lat_pre_adv", advance, 1'b0);
    cycle();
    check("lat_adv", advance, 1'b1);
    check("lat_state", state, 2'b01);
    step = 1'b0;
    cycle();
    check("lat_pc", pc, 8'h01);
    check("lat_state_idle", state, 2'b00);
    check("lat_adv_off", advance, 1'b0);
    repeat (6) cycle();
    check("lat_adv_total", adv_cnt, 1);

    // Branch taken / not taken from pc=0x10.
    jump = 1'b1; instr = 32'h0000_0010;
    do_step("jmp10a", 8'h10);
    jump = 1'b0; branch = 1'b1; zero = 1'b1; instr = 32'h0000_00FE;
    do_step("br_taken", 8'h0F);
    jump = 1'b1; branch = 1'b0; instr = 32'h0000_0010;
    do_step("jmp10b", 8'h10);
    jump = 1'b0; branch = 1'b1; zero = 1'b0; instr = 32'h0000_00FE;
    do_step("br_not_taken", 8'h11);
    branch = 1'b0;

    // Wrap-around and jump.
    jump = 1'b1; instr = 32'h0000_00FF;
    do_step("jmpff", 8'hFF);
    check("pc_plus1_wrap", pc_plus1, 8'h00);
    jump = 1'b0; instr = 32'h2001_0005;
    do_step("wrap", 8'h00);
    jump = 1'b1; instr = 32'h0000_003C;
    do_step("jmp3c", 8'h3C);
    jump = 1'b0; instr = 32'h2001_0005;

    // Run mode: one advance every 4 cycles.
    pulse_reset();
    check("run_rst_pc", pc, 8'h00);
    a0 = adv_cnt;
    run = 1'b1;
    repeat (5) cycle();
    check("run_pc1", pc, 8'h01);
    repeat (4) cycle();
    check("run_pc2", pc, 8'h02);
    repeat (4) cycle();
    check("run_pc3", pc, 8'h03);
    check("run_state", state, 2'b10);
    check("run_adv_cnt", adv_cnt - a0, 3);
    run = 1'b0;
    cycle();
    check("run_stop_state", state, 2'b00);
    repeat (8) cycle();
    check("run_stop_adv", adv_cnt - a0, 3);
    check("run_stop_pc", pc, 8'h03);

    // Halt word at terminal count in run mode.
    jump = 1'b1; instr = 32'h0000_0005;
    do_step("jmp05", 8'h05);
    jump = 1'b0; instr = 32'h2001_0005;
    run = 1'b1;
    repeat (3) cycle();
    instr = 32'hFFFF_FFFF;
    check("halt_cnt2_state", state, 2'b10);
    a0 = adv_cnt;
    cycle();
    check("halt_term_adv", advance, 1'b0);
    check("halt_term_state", state, 2'b10);
    cycle();
    check("halt_state", state, 2'b11);
    check("halt_flag", halted, 1'b1);
    check("halt_pc", pc, 8'h05);
    run = 1'b0; step = 1'b1;
    repeat (4) cycle();
    step = 1'b0; run = 1'b1;
    repeat (4) cycle();
    run = 1'b0;
    instr = 32'h2001_0005;
    repeat (4) cycle();
    check("halt_abs_state", state, 2'b11);
    check("halt_abs_pc", pc, 8'h05);
    check("halt_abs_adv", adv_cnt - a0, 0);
    rst = 1'b0;
    #2;
    check("halt_rst_pc", pc, 8'h00);
    check("halt_rst_state", state, 2'b00);
    check("halt_rst_flag", halted, 1'b0);
    rst = 1'b1;
    cycle();

    // Held step yields a single advance.
    jump = 1'b1; instr = 32'h0000_0030;
    a0 = adv_cnt;
    step = 1'b1;
    repeat (20) cycle();
    step = 1'b0;
    repeat (5) cycle();
    check("hold_adv", adv_cnt - a0, 1);
    check("hold_pc", pc, 8'h30);

    // Reset during the advance cycle aborts the update.
    jump = 1'b0; instr = 32'h2001_0005;
    step = 1'b1;
    repeat (3) cycle();
    check("abort_adv_pre", advance, 1'b1);
    rst = 1'b0;
    step = 1'b0;
    #1;
    check("abort_pc", pc, 8'h00);
    check("abort_adv", advance, 1'b0);
    check("abort_state", state, 2'b00);
    a0 = adv_cnt;
    repeat (2) cycle();
    rst = 1'b1;
    repeat (4) cycle();
    check("abort_pc_after", pc, 8'h00);
    check("abort_state_after", state, 2'b00);
    check("abort_adv_after", adv_cnt - a0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
